// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: byte-lane data RAM, 1-cycle registered load, WB bundle.
// Define MEM_WB_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] link_data,
  input  logic              is_jump,
  input  logic              mem_to_reg,
  input  logic              mem_wrenable,
  input  logic              reg_wrenable,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic              wb_valid,
  output logic              wb_reg_wrenable,
  output logic [REG_AW-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_trap
);

  localparam int NB    = DATA_W / 8;
  localparam int BS    = $clog2(NB);
  localparam int DEPTH = 2 ** ADDR_W;

  logic              fire;
  logic [ADDR_W-1:0] idx;
  logic [BS-1:0]     off;
  logic [BS-1:0]     off_al;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              rwe_acc;

  assign fire = in_valid & ~stall & rst_n;
  assign idx  = alu_res[ADDR_W+BS-1:BS];
  assign off  = alu_res[BS-1:0];

  always_comb begin
    off_al = off;
    unique case (mem_size)
      2'b00:   off_al = off;
      2'b01:   off_al = off & ~BS'(1);
      default: off_al = '0;
    endcase
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic mis;
  logic trap_q;
  logic trap_d;

  always_comb begin
    mis = 1'b0;
    unique case (mem_size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      default: mis = |off;
    endcase
  end

  assign rwe_acc = reg_wrenable & ~(mis & mem_to_reg);
`else
  assign rwe_acc = reg_wrenable;
`endif

  // Replicate the right-aligned store data into every lane it may land in.
  always_comb begin
    be    = '0;
    wdata = '0;
    for (int i = 0; i < NB; i++) begin
      unique case (mem_size)
        2'b00: begin
          be[i]          = (BS'(i) == off_al);
          wdata[i*8 +: 8] = store_data[7:0];
        end
        2'b01: begin
          be[i]          = ((i >> 1) == (int'(off_al) >> 1));
          wdata[i*8 +: 8] = (i % 2 == 0) ? store_data[7:0]
                                         : store_data[15:8];
        end
        default: begin
          be[i]          = 1'b1;
          wdata[i*8 +: 8] = store_data[i*8 +: 8];
        end
      endcase
    end
`ifdef MEM_WB_MISALIGN_TRAP_EN
    if (mis) be = '0;
`endif
  end

  assign we = fire & mem_wrenable;

  logic [DATA_W-1:0] ram_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) ram_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] link_q;
  logic              jump_q;
  logic              m2r_q;
  logic              rwe_q;
  logic [REG_AW-1:0] wreg_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [BS-1:0]     off_q;
  logic              valid_q;
  logic              valid_d;

  assign valid_d = fire ? 1'b1 : (stall ? valid_q : 1'b0);

  // Read-before-write: a load/store pair in one cycle returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      alu_q   <= '0;
      link_q  <= '0;
      jump_q  <= 1'b0;
      m2r_q   <= 1'b0;
      rwe_q   <= 1'b0;
      wreg_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (fire) begin
        rd_q   <= ram_q[idx];
        alu_q  <= alu_res;
        link_q <= link_data;
        jump_q <= is_jump;
        m2r_q  <= mem_to_reg;
        rwe_q  <= rwe_acc;
        wreg_q <= write_reg;
        size_q <= mem_size;
        uns_q  <= mem_unsigned;
        off_q  <= off_al;
      end
    end
  end

`ifdef MEM_WB_MISALIGN_TRAP_EN
  assign trap_d = fire ? mis : (stall ? trap_q : 1'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end

  assign wb_trap = trap_q;
`else
  assign wb_trap = 1'b0;
`endif

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ld_ext;

  assign sh = rd_q >> {off_q, 3'b000};

  always_comb begin
    ld_ext = rd_q;
    unique case (size_q)
      2'b00:
        ld_ext = uns_q ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                       : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      2'b01:
        ld_ext = uns_q ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                       : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default:
        ld_ext = rd_q;
    endcase
  end

  assign wb_valid        = valid_q;
  assign wb_reg_wrenable = valid_q & rwe_q;
  assign wb_write_reg    = wreg_q;
  assign wb_write_data   = jump_q ? link_q : (m2r_q ? ld_ext : alu_q);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Table-driven bench for mem_wb_stage with an expected-result queue.
// Build with MEM_WB_MISALIGN_TRAP_EN to cover the trapping variant.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall;
  logic [31:0] alu_res, store_data, link_data;
  logic        is_jump, mem_to_reg, mem_wrenable, reg_wrenable;
  logic [4:0]  write_reg;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        wb_valid, wb_reg_wrenable, wb_trap;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;

  mem_wb_stage #(.DATA_W(32), .ADDR_W(8), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
    .alu_res(alu_res), .store_data(store_data), .link_data(link_data),
    .is_jump(is_jump), .mem_to_reg(mem_to_reg),
    .mem_wrenable(mem_wrenable), .reg_wrenable(reg_wrenable),
    .write_reg(write_reg), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .wb_valid(wb_valid),
    .wb_reg_wrenable(wb_reg_wrenable), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data), .wb_trap(wb_trap)
  );

  always #5 clk = ~clk;

`ifdef MEM_WB_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    bit          v;
    bit          rwe;
    logic [4:0]  wr;
    logic [31:0] d;
    bit          t;
  } exp_t;

  typedef struct {
    bit          iv, st;
    logic [31:0] alu, sd, lnk;
    bit          j, m2r, mwe, rwe;
    logic [4:0]  wr;
    logic [1:0]  sz;
    bit          u;
    exp_t        e;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tv[$];

  function automatic vec_t mk(
    bit iv, bit st, logic [31:0] alu, logic [31:0] sd,
    logic [31:0] lnk, bit j, bit m2r, bit mwe, bit rwe,
    logic [4:0] wr, logic [1:0] sz, bit u,
    bit ev, bit erwe, logic [4:0] ewr, logic [31:0] ed, bit et);
    vec_t x;
    x.iv = iv; x.st = st; x.alu = alu; x.sd = sd; x.lnk = lnk;
    x.j = j; x.m2r = m2r; x.mwe = mwe; x.rwe = rwe;
    x.wr = wr; x.sz = sz; x.u = u;
    x.e.v = ev; x.e.rwe = erwe; x.e.wr = ewr; x.e.d = ed; x.e.t = et;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t x);
    in_valid = x.iv; stall = x.st; alu_res = x.alu;
    store_data = x.sd; link_data = x.lnk; is_jump = x.j;
    mem_to_reg = x.m2r; mem_wrenable = x.mwe;
    reg_wrenable = x.rwe; write_reg = x.wr;
    mem_size = x.sz; mem_unsigned = x.u;
  endtask

  task automatic cmp_out(string tag, exp_t e);
    chk({tag, ".valid"}, 32'(wb_valid), 32'(e.v));
    chk({tag, ".rwe"},   32'(wb_reg_wrenable), 32'(e.rwe));
    chk({tag, ".wreg"},  32'(wb_write_reg), 32'(e.wr));
    chk({tag, ".data"},  wb_write_data, e.d);
    chk({tag, ".trap"},  32'(wb_trap), 32'(e.t));
  endtask

  // Called at a negedge; leaves at the following negedge.
  task automatic step(vec_t x, string tag);
    exp_t e;
    drive(x);
    sb.push_back(x.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.sb: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      cmp_out(tag, e);
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t z;
    z.v = 0; z.rwe = 0; z.wr = 0; z.d = 0; z.t = 0;

    rst_n = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    #12;
    cmp_out("reset", z);
    @(negedge clk);
    rst_n = 1'b1;

    //      iv st alu         sd           lnk  j m2r mwe rwe wr sz u  ev rwe wr  data         trap
    tv.push_back(mk(1,0,32'h10, 32'hDEADBEEF,0,0,0,1,0, 0,2'd2,0, 1,0, 0,32'h10,0));
    tv.push_back(mk(1,0,32'h10, 0,           0,0,1,0,1, 5,2'd2,0, 1,1, 5,32'hDEADBEEF,0));
    tv.push_back(mk(1,0,32'h11, 32'h80,      0,0,0,1,0, 0,2'd0,0, 1,0, 0,32'h11,0));
    tv.push_back(mk(1,0,32'h11, 0,           0,0,1,0,1, 6,2'd0,0, 1,1, 6,32'hFFFFFF80,0));
    tv.push_back(mk(1,0,32'h11, 0,           0,0,1,0,1, 7,2'd0,1, 1,1, 7,32'h00000080,0));
    tv.push_back(mk(1,0,32'h10, 0,           0,0,1,0,1, 8,2'd2,0, 1,1, 8,32'hDEAD80EF,0));
    tv.push_back(mk(1,0,32'h123,0,       32'h42,1,1,0,1, 1,2'd2,0, 1,1, 1,32'h42,0));
    tv.push_back(mk(1,0,32'h7,  0,           0,0,0,0,1, 2,2'd2,0, 1,1, 2,32'h7,0));
    tv.push_back(mk(0,0,32'h99, 0,           0,0,0,0,1, 9,2'd2,0, 0,0, 2,32'h7,0));
    tv.push_back(mk(1,0,32'h12, 0,           0,0,1,0,1, 3,2'd1,0, 1,1, 3,32'hFFFFDEAD,0));
    tv.push_back(mk(1,0,32'h10, 0,           0,0,1,0,1, 4,2'd1,1, 1,1, 4,32'h000080EF,0));
    tv.push_back(mk(1,1,32'h10, 32'h11111111,0,0,0,1,0, 0,2'd2,0, 1,1, 4,32'h000080EF,0));
    tv.push_back(mk(0,1,32'h10, 0,           0,0,0,0,0, 0,2'd2,0, 1,1, 4,32'h000080EF,0));
    tv.push_back(mk(1,0,32'h10, 0,           0,0,1,0,1, 9,2'd2,0, 1,1, 9,32'hDEAD80EF,0));
    tv.push_back(mk(1,0,32'h13, 32'h1234,    0,0,0,1,0, 0,2'd1,0, 1,0, 0,32'h13,TRAP));
    tv.push_back(mk(1,0,32'h10, 0,           0,0,1,0,1,10,2'd2,0, 1,1,10,
                    TRAP ? 32'hDEAD80EF : 32'h123480EF, 0));
    tv.push_back(mk(1,0,32'h410,32'hCAFEF00D,0,0,0,1,0, 0,2'd2,0, 1,0, 0,32'h410,0));
    tv.push_back(mk(1,0,32'h10, 0,           0,0,1,0,1,15,2'd2,0, 1,1,15,32'hCAFEF00D,0));
    tv.push_back(mk(1,1,32'h11, 0,           0,0,1,0,1, 3,2'd0,0, 1,1,15,32'hCAFEF00D,0));
    tv.push_back(mk(1,0,32'h11, 0,           0,0,1,0,1,11,2'd2,0, 1,!TRAP,11,32'hCAFEF00D,TRAP));
    tv.push_back(mk(1,1,32'h0,  0,           0,0,0,0,0, 0,2'd2,0, 1,!TRAP,11,32'hCAFEF00D,TRAP));
    tv.push_back(mk(0,0,32'h0,  0,           0,0,0,0,0, 0,2'd2,0, 0,0,11,32'hCAFEF00D,0));
    tv.push_back(mk(1,0,32'h10, 32'h55,      0,0,1,1,1,12,2'd2,0, 1,1,12,32'hCAFEF00D,0));
    tv.push_back(mk(1,0,32'h10, 0,           0,0,1,0,1,12,2'd2,0, 1,1,12,32'h00000055,0));
    tv.push_back(mk(1,0,32'h20, 32'hAAAA5555,0,0,0,1,0,13,2'd2,0, 1,0,13,32'h20,0));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i], $sformatf("vec%0d", i));
    end

    // Reset asserted alongside a store: outputs clear at once, store dropped.
    drive(mk(1,0,32'h20,32'h12345678,0,0,0,1,1,14,2'd2,0, 0,0,0,0,0));
    rst_n = 1'b0;
    #1;
    cmp_out("midrst", z);
    @(posedge clk);
    #1;
    cmp_out("midrst_edge", z);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1,0,32'h20,0,0,0,1,0,1,14,2'd2,0, 1,1,14,32'hAAAA5555,0),
         "postrst");

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised memory/write-back stage of the pipelined CPU.
- Contains an inferred synchronous data RAM with byte lanes, byte/half/word loads and stores, and sign or zero extension.
- Registers the write-back bundle (valid, register enable, destination register, data) one cycle after acceptance.
- Sits between the execute stage and the register file; adds stall handling and optional misalignment trapping.

Parameters:
- DATA_W, 32, datapath width; must be a multiple of 8 and at least 16.
- ADDR_W, 8, word-index bits; RAM depth is 2**ADDR_W words.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  stage clock; RAM is clocked by clk (no separate PLL clock).
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an instruction is presented this cycle.
- stall  in  1  freeze the stage; the input is not accepted and outputs are held.
- alu_res  in  DATA_W  ALU result; the byte address for memory operations.
- store_data  in  DATA_W  store data, right-aligned.
- link_data  in  DATA_W  return address (pc+1), used when is_jump.
- is_jump  in  1  select link_data for write-back.
- mem_to_reg  in  1  load; select the extended RAM data.
- mem_wrenable  in  1  store.
- reg_wrenable  in  1  the instruction writes a register.
- write_reg  in  REG_AW  destination register.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- wb_valid  out  1  the write-back bundle is valid.
- wb_reg_wrenable  out  1  register-file write enable (already qualified by wb_valid).
- wb_write_reg  out  REG_AW  destination register.
- wb_write_data  out  DATA_W  write-back data.
- wb_trap  out  1  misaligned access flag.

Behaviour:
- Reset:
  - rst_n low asynchronously clears wb_valid, wb_reg_wrenable, wb_write_reg, wb_write_data, wb_trap and all internal pipeline registers to 0.
  - RAM contents are not reset.
- Accept: fire = in_valid & ~stall & rst_n. The stage samples inputs only on fire.
- Addressing:
  - BS = log2(DATA_W/8).
  - Word index = alu_res[ADDR_W+BS-1:BS]; byte offset = alu_res[BS-1:0].
  - Address bits above the index are ignored, so the address wraps modulo the depth.
- Store (fire & mem_wrenable), written at the accepting edge:
  - Byte: store_data[7:0] goes to lane = offset.
  - Half: store_data[15:0] goes to lanes offset and offset+1, using offset with bit 0 cleared.
  - Word: all lanes.
  - Only the enabled lanes change.
- Load: the RAM read is issued at the accepting edge.
  - A 1-cycle registered read; size, unsigned and offset are pipelined alongside.
  - In the next cycle, the selected lane(s) are shifted to bit 0 and extended per mem_unsigned.
  - A store at cycle N followed by a load of the same word at N+1 returns the new data.
- Write-back select: is_jump ? link_data : (mem_to_reg ? extended load : alu_res).
- Latency: 1 cycle.
  - Outputs update on the edge after fire.
  - With no fire and no stall, wb_valid goes to 0 on that edge and the other outputs hold.
- Stall:
  - No RAM write.
  - All output and pipeline registers hold, including wb_valid.
  - The RAM read port is held, so a pending load result stays stable.
- Reset mid-operation: if rst_n is low at an edge, the store at that edge is dropped and the in-flight bundle is discarded.
- Simultaneous flags:
  - is_jump overrides mem_to_reg.
  - mem_wrenable with mem_to_reg is illegal; the store is performed and write-back takes the loaded (old) data.

Optional Feature:
- Macro MEM_WB_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access raises wb_trap with the bundle: a half access with offset bit 0 set, or a word access with a nonzero offset.
  - A misaligned store writes nothing.
  - A misaligned load forces wb_reg_wrenable=0.
  - wb_trap holds during stall and otherwise clears on the next edge.
- Undefined:
  - wb_trap is tied 0.
  - Misaligned offsets are silently aligned down: half uses offset&~1, word uses offset 0.

Test Plan:
- Reset, then store word 0xDEADBEEF at address 0x10; next cycle load word from 0x10 -> wb_write_data=0xDEADBEEF one cycle later, wb_reg_wrenable=1.
- Store byte 0x80 at address 0x11; load signed byte from 0x11 -> 0xFFFFFF80; load unsigned byte -> 0x00000080; load word from 0x10 -> 0xDEAD80EF.
- Jump with link_data=0x00000042, alu_res=0x123, mem_to_reg=1 -> wb_write_data=0x42; plain ALU op with alu_res=0x7 -> wb_write_data=0x7.
- Store attempted with stall=1 -> RAM unchanged (later load returns old data); wb outputs held throughout the stall; wb_valid=0 after a cycle with in_valid=0.
- Assert rst_n low in the same cycle as a store to 0x20 -> all outputs 0 immediately; a later load from 0x20 returns the prior contents.
- With the macro: half store to address 0x13 -> wb_trap=1, no write. Without the macro: the same store writes lanes 2–3 of word 4.
